// File: rtl/controller_shared_ram.sv
// ---------------------------------------------------------------------------
// controller_shared_ram
//
// One inferred single-port 32-bit word RAM shared by two masters:
//   * the soft-CPU port (request/ack handshake, byte-enabled writes), and
//   * the host-bridge port (one-cycle rd/wr strobes, already synchronised
//     into this clock domain), buffered by a one-entry pending register.
// A three-state FSM (IDLE, CPU_ACK, BRG_ACK) arbitrates round-robin between
// the CPU request and the pending bridge entry. A grant in cycle N issues the
// RAM access in N and produces the ack / read-valid pulse in N+1. The next
// grant can come no earlier than N+2.
//
// Parameters
//   TOP_ADDRESS   bridge_addr[31:16] value that selects this RAM
//   ADDR_W        word-address width (depth 2**ADDR_W, legal 8..14)
//   PROTECT_WORDS number of low words that CPU writes may not modify
//                 while wp_en=1 (write-protect build only)
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cpu_req/we/addr       CPU request, held until cpu_ack
//   cpu_bytesel, cpu_d    CPU write byte enables and data
//   cpu_q, cpu_ack        CPU read data (valid with ack, then held), ack pulse
//   bridge_addr           bridge byte address (word = [ADDR_W+1:2])
//   bridge_rd/wr          one-cycle bridge strobes
//   bridge_wr_data        bridge write data (always a full word)
//   bridge_rd_data        bridge read data, held until the next bridge read
//   bridge_rd_valid       one-cycle pulse when bridge_rd_data updates
//   bridge_busy           pending bridge entry occupied
//   bridge_overflow       sticky: an in-window strobe was dropped
//   wp_en                 write-protect enable (write-protect build only)
//
// Build option
//   CONTROLLER_RAM_WRITE_PROTECT_EN  adds wp_en; CPU writes below
//   PROTECT_WORDS are suppressed while wp_en=1 (still acked). Bridge writes
//   are never protected.
// ---------------------------------------------------------------------------
module controller_shared_ram #(
   parameter logic [15:0] TOP_ADDRESS   = 16'h8000,
   parameter int          ADDR_W        = 12,
   parameter int          PROTECT_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [3:0]        cpu_bytesel,
   input  logic [31:0]       cpu_d,
   output logic [31:0]       cpu_q,
   output logic              cpu_ack,
   input  logic [31:0]       bridge_addr,
   input  logic              bridge_rd,
   input  logic              bridge_wr,
   input  logic [31:0]       bridge_wr_data,
   output logic [31:0]       bridge_rd_data,
   output logic              bridge_rd_valid,
   output logic              bridge_busy,
`ifdef CONTROLLER_RAM_WRITE_PROTECT_EN
   input  logic              wp_en,
`endif
   output logic              bridge_overflow
);

   localparam int          DEPTH       = 1 << ADDR_W;
   localparam logic [31:0] PROTECT_LIM = 32'(PROTECT_WORDS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CPU_ACK = 2'd1,
      S_BRG_ACK = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_CPU = 1'b0,
      GRANT_BRG = 1'b1
   } grant_e;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_e              state_q;
   grant_e              last_grant_q;

   logic                pend_valid_q;
   logic                pend_we_q;
   logic [ADDR_W-1:0]   pend_addr_q;
   logic [31:0]         pend_data_q;

   logic                cpu_ack_q;     // high throughout CPU_ACK
   logic                cpu_rd_q;      // CPU_ACK is completing a read
   logic [31:0]         cpu_hold_q;    // last CPU read data
   logic                brg_valid_q;   // high throughout BRG_ACK of a read
   logic [31:0]         brg_hold_q;    // last bridge read data
   logic                overflow_q;

   logic [31:0]         mem_q [0:DEPTH-1];
   logic [31:0]         ram_rdata_q;

   // -------------------------------------------------------------------------
   // Bridge strobe decode
   // -------------------------------------------------------------------------
   logic                window_hit;
   logic                strobe_wr;
   logic                strobe_rd;
   logic                strobe;
   logic [ADDR_W-1:0]   bridge_word;
   logic                unused_addr_bits;

   assign window_hit  = (bridge_addr[31:16] == TOP_ADDRESS);
   // A simultaneous rd+wr keeps only the write; the read is not a drop.
   assign strobe_wr   = window_hit & bridge_wr;
   assign strobe_rd   = window_hit & bridge_rd & ~bridge_wr;
   assign strobe      = strobe_wr | strobe_rd;
   assign bridge_word = bridge_addr[ADDR_W+1:2];
   // Byte offset and bits between the word index and the window are don't-care.
   assign unused_addr_bits = ^bridge_addr[15:0];

   // -------------------------------------------------------------------------
   // Write protection (constant 0 unless the write-protect build is used)
   // -------------------------------------------------------------------------
   logic wp_gate;
   logic cpu_protect;

`ifdef CONTROLLER_RAM_WRITE_PROTECT_EN
   assign wp_gate = wp_en;
`else
   assign wp_gate = 1'b0;
`endif

   assign cpu_protect = wp_gate && (32'(cpu_addr) < PROTECT_LIM);

   // -------------------------------------------------------------------------
   // Arbitration: only IDLE grants; a tie goes to whoever was not served last.
   // -------------------------------------------------------------------------
   logic grant_cpu;
   logic grant_brg;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned; otherwise a latch is inferred.
      grant_cpu = 1'b0;
      grant_brg = 1'b0;
      if (state_q == S_IDLE) begin
         if (cpu_req && pend_valid_q) begin
            if (last_grant_q == GRANT_BRG) grant_cpu = 1'b1;
            else                           grant_brg = 1'b1;
         end else if (cpu_req) begin
            grant_cpu = 1'b1;
         end else if (pend_valid_q) begin
            grant_brg = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // RAM port mux: the granted master drives the single RAM port.
   // -------------------------------------------------------------------------
   logic                ram_en;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [31:0]         ram_wdata;
   logic [3:0]          ram_be;

   assign ram_en    = grant_cpu | grant_brg;
   assign ram_we    = grant_cpu ? cpu_we   : pend_we_q;
   assign ram_addr  = grant_cpu ? cpu_addr : pend_addr_q;
   assign ram_wdata = grant_cpu ? cpu_d    : pend_data_q;
   // A protected CPU write still occupies the RAM slot and is acked; it just
   // enables no bytes.
   assign ram_be    = grant_cpu ? (cpu_bytesel & {4{~cpu_protect}}) : 4'hF;

   // NOTE: the RAM array and its read register carry no reset so the tools
   // can map them onto block RAM; contents survive reset_n.
   always_ff @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_be[b]) mem_q[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end else begin
            ram_rdata_q <= mem_q[ram_addr];
         end
      end
   end

   // -------------------------------------------------------------------------
   // FSM, pending buffer and registered outputs
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= GRANT_BRG;   // CPU wins the first tie
         pend_valid_q <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         cpu_ack_q    <= 1'b0;
         cpu_rd_q     <= 1'b0;
         cpu_hold_q   <= '0;
         brg_valid_q  <= 1'b0;
         brg_hold_q   <= '0;
         overflow_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_cpu) begin
                  state_q      <= S_CPU_ACK;
                  last_grant_q <= GRANT_CPU;
                  cpu_ack_q    <= 1'b1;
                  cpu_rd_q     <= ~cpu_we;
               end else if (grant_brg) begin
                  state_q      <= S_BRG_ACK;
                  last_grant_q <= GRANT_BRG;
                  brg_valid_q  <= ~pend_we_q;
               end
            end
            S_CPU_ACK: begin
               if (cpu_rd_q) cpu_hold_q <= ram_rdata_q;
               cpu_ack_q <= 1'b0;
               cpu_rd_q  <= 1'b0;
               state_q   <= S_IDLE;
            end
            S_BRG_ACK: begin
               if (brg_valid_q) brg_hold_q <= ram_rdata_q;
               brg_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase

         // Pending buffer. busy is judged on the pre-edge value, so a strobe
         // arriving in the cycle the entry is granted is still dropped.
         if (grant_brg) pend_valid_q <= 1'b0;
         if (strobe) begin
            if (!pend_valid_q) begin
               pend_valid_q <= 1'b1;
               pend_we_q    <= strobe_wr;
               pend_addr_q  <= bridge_word;
               pend_data_q  <= bridge_wr_data;
            end else begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // Read data appears on the outputs in the ack cycle straight from the RAM
   // read register, then the hold register keeps it until the next read.
   assign cpu_ack         = cpu_ack_q;
   assign cpu_q           = cpu_rd_q ? ram_rdata_q : cpu_hold_q;
   assign bridge_rd_valid = brg_valid_q;
   assign bridge_rd_data  = brg_valid_q ? ram_rdata_q : brg_hold_q;
   assign bridge_busy     = pend_valid_q;
   assign bridge_overflow = overflow_q;

endmodule

// File: tb/tb_controller_shared_ram.sv
// ---------------------------------------------------------------------------
// tb_controller_shared_ram
//
// Self-checking bench for controller_shared_ram: reset values, a table of CPU
// byte-enable accesses, bridge window decode, randomized concurrent CPU and
// bridge traffic against a word-array model, round-robin contention, overflow,
// reset in the middle of a bridge read, and (write-protect build) protection.
// ---------------------------------------------------------------------------
module tb_controller_shared_ram;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [3:0]        cpu_bytesel;
   logic [31:0]       cpu_d;
   logic [31:0]       cpu_q;
   logic              cpu_ack;
   logic [31:0]       bridge_addr;
   logic              bridge_rd;
   logic              bridge_wr;
   logic [31:0]       bridge_wr_data;
   logic [31:0]       bridge_rd_data;
   logic              bridge_rd_valid;
   logic              bridge_busy;
   logic              bridge_overflow;
`ifdef CONTROLLER_RAM_WRITE_PROTECT_EN
   logic              wp_en;
`endif

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   controller_shared_ram #(
      .TOP_ADDRESS   (16'h8000),
      .ADDR_W        (ADDR_W),
      .PROTECT_WORDS (256)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cpu_req         (cpu_req),
      .cpu_we          (cpu_we),
      .cpu_addr        (cpu_addr),
      .cpu_bytesel     (cpu_bytesel),
      .cpu_d           (cpu_d),
      .cpu_q           (cpu_q),
      .cpu_ack         (cpu_ack),
      .bridge_addr     (bridge_addr),
      .bridge_rd       (bridge_rd),
      .bridge_wr       (bridge_wr),
      .bridge_wr_data  (bridge_wr_data),
      .bridge_rd_data  (bridge_rd_data),
      .bridge_rd_valid (bridge_rd_valid),
      .bridge_busy     (bridge_busy),
`ifdef CONTROLLER_RAM_WRITE_PROTECT_EN
      .wp_en           (wp_en),
`endif
      .bridge_overflow (bridge_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] baddr(input int w);
      return {16'h8000, 16'(w * 4)};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // CPU access: lat = cycles from request to ack (1 when uncontended), -1 on timeout.
   task automatic cpu_access(input logic we, input int a, input logic [3:0] be,
                             input logic [31:0] d, output logic [31:0] q, output int lat);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a[ADDR_W-1:0]; cpu_bytesel = be; cpu_d = d;
      lat = -1; q = '0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (cpu_ack) begin
            lat = i; q = cpu_q;
            break;
         end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   // Bridge read: strobe cycle is cycle 1; lat = cycle holding rd_valid, -1 on timeout.
   task automatic brg_read(input int w, output logic [31:0] q, output int lat);
      @(posedge clk); #1;
      bridge_addr = baddr(w); bridge_rd = 1'b1;
      lat = -1; q = '0;
      for (int i = 2; i <= 16; i++) begin
         @(posedge clk); #1;
         bridge_rd = 1'b0;
         @(negedge clk);
         if (bridge_rd_valid) begin
            lat = i; q = bridge_rd_data;
            break;
         end
      end
      bridge_rd = 1'b0;
   endtask

   // Bridge write: waits until the pending buffer is empty again.
   // lat = 1 when the strobe was never captured, -1 on timeout.
   task automatic brg_write(input logic [31:0] a, input logic [31:0] d, output int lat);
      @(posedge clk); #1;
      bridge_addr = a; bridge_wr = 1'b1; bridge_wr_data = d;
      lat = -1;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         bridge_wr = 1'b0;
         @(negedge clk);
         if (!bridge_busy) begin
            lat = i;
            break;
         end
      end
      bridge_wr = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // CPU vector table
   // ------------------------------------------------------------------------
   typedef struct {
      logic        we;
      int          addr;
      logic [3:0]  be;
      logic [31:0] d;
      logic [31:0] exp_q;   // read data, or the held cpu_q after a write
   } vec_t;

   vec_t tbl [13];

   logic [31:0] cpu_m [0:15];   // model of words 0..15 (CPU region)
   logic [31:0] brg_m [0:15];   // model of words 32..47 (bridge region)

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      logic [31:0] q;
      int          lat;
      int          seen;
      int          ev [$];
      int          st_q [$];
      logic [31:0] ex_q [$];
      int          first_b;
      int          last_b;
      int          n_b;
      int          both;

      reset_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_bytesel = '0; cpu_d = '0;
      bridge_addr = '0; bridge_rd = 1'b0; bridge_wr = 1'b0; bridge_wr_data = '0;
`ifdef CONTROLLER_RAM_WRITE_PROTECT_EN
      wp_en = 1'b0;
`endif

      tbl[0]  = '{1'b1, 5,    4'hF, 32'h11223344, 32'h00000000};
      tbl[1]  = '{1'b1, 5,    4'h3, 32'hDEADBEEF, 32'h00000000};
      tbl[2]  = '{1'b0, 5,    4'hF, 32'h0,        32'h1122BEEF};
      tbl[3]  = '{1'b1, 7,    4'hF, 32'h00000000, 32'h1122BEEF};
      tbl[4]  = '{1'b1, 7,    4'h8, 32'hA5A5A5A5, 32'h1122BEEF};
      tbl[5]  = '{1'b1, 7,    4'h4, 32'h00C30000, 32'h1122BEEF};
      tbl[6]  = '{1'b0, 7,    4'h0, 32'h0,        32'hA5C30000};
      tbl[7]  = '{1'b1, 5,    4'h0, 32'hFFFFFFFF, 32'hA5C30000};
      tbl[8]  = '{1'b0, 5,    4'hF, 32'h0,        32'h1122BEEF};
      tbl[9]  = '{1'b1, 4095, 4'hF, 32'h12345678, 32'h1122BEEF};
      tbl[10] = '{1'b0, 4095, 4'hF, 32'h0,        32'h12345678};
      tbl[11] = '{1'b1, 4095, 4'h1, 32'h000000AB, 32'h12345678};
      tbl[12] = '{1'b0, 4095, 4'hF, 32'h0,        32'h123456AB};

      // ---- reset values ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_q",      cpu_q, 32'h0);
      check("rst_cpu_ack",    32'(cpu_ack), 32'h0);
      check("rst_rd_data",    bridge_rd_data, 32'h0);
      check("rst_rd_valid",   32'(bridge_rd_valid), 32'h0);
      check("rst_busy",       32'(bridge_busy), 32'h0);
      check("rst_overflow",   32'(bridge_overflow), 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // ---- power-up bridge read of word 0: strobe, grant, valid in cycle 3 ----
      brg_read(0, q, lat);
      check("pwrup_rd_latency", 32'(lat), 32'd3);

      // ---- CPU table: byte enables, held cpu_q on writes, ack latency ----
      for (int i = 0; i < 13; i++) begin
         cpu_access(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].d, q, lat);
         check($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
         check($sformatf("tbl%0d_ack_lat", i), 32'(lat), 32'd1);
      end
      @(negedge clk);
      check("ack_one_cycle", 32'(cpu_ack), 32'h0);

      // ---- window decode ----
      brg_write(32'h8000_0010, 32'hCAFE0001, lat);
      check("win_wr_done", 32'(lat), 32'd2);
      brg_read(4, q, lat);
      check("win_rd_data", q, 32'hCAFE0001);
      check("win_rd_latency", 32'(lat), 32'd3);
      brg_write(32'h9000_0010, 32'h0BADF00D, lat);
      check("oow_not_captured", 32'(lat), 32'd1);
      brg_read(4, q, lat);
      check("oow_word4_kept", q, 32'hCAFE0001);
      check("oow_no_overflow", 32'(bridge_overflow), 32'h0);
      check("rd_data_held", bridge_rd_data, 32'hCAFE0001);

      // ---- simultaneous rd+wr: write kept, no read pulse, no overflow ----
      @(posedge clk); #1;
      bridge_addr = baddr(8); bridge_rd = 1'b1; bridge_wr = 1'b1; bridge_wr_data = 32'h5A5A0008;
      @(posedge clk); #1;
      bridge_rd = 1'b0; bridge_wr = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bridge_rd_valid) seen = 1;
      end
      check("rdwr_no_valid", 32'(seen), 32'h0);
      check("rdwr_no_overflow", 32'(bridge_overflow), 32'h0);
      cpu_access(1'b0, 8, 4'hF, 32'h0, q, lat);
      check("rdwr_write_kept", q, 32'h5A5A0008);

      // ---- randomized concurrent traffic against the word model ----
      for (int w = 0; w < 16; w++) begin
         cpu_m[w] = $urandom;
         cpu_access(1'b1, w, 4'hF, cpu_m[w], q, lat);
         brg_m[w] = $urandom;
         brg_write(baddr(32 + w), brg_m[w], lat);
      end
      fork
         begin : cpu_proc
            logic [31:0] cq;
            logic [31:0] held;
            int          cl;
            int          w;
            logic [3:0]  be;
            logic [31:0] d;
            held = cq;
            cpu_access(1'b0, 0, 4'hF, 32'h0, cq, cl);
            check("rnd_cpu_rd", cq, cpu_m[0]);
            held = cq;
            for (int n = 0; n < 40; n++) begin
               w = $urandom_range(0, 15);
               if ($urandom_range(0, 1) == 1) begin
                  be = 4'($urandom);
                  d  = $urandom;
                  cpu_access(1'b1, w, be, d, cq, cl);
                  cpu_m[w] = merge(cpu_m[w], d, be);
                  check("rnd_cpu_wr_q_held", cq, held);
               end else begin
                  cpu_access(1'b0, w, 4'hF, 32'h0, cq, cl);
                  check("rnd_cpu_rd", cq, cpu_m[w]);
                  held = cpu_m[w];
               end
               check("rnd_cpu_lat_ok", 32'(cl >= 1 && cl <= 3), 32'h1);
               repeat ($urandom_range(0, 3)) @(posedge clk);
            end
         end
         begin : brg_proc
            logic [31:0] bq;
            int          bl;
            int          w;
            int          op;
            logic [31:0] d;
            for (int n = 0; n < 40; n++) begin
               w  = $urandom_range(0, 15);
               op = $urandom_range(0, 5);
               d  = $urandom;
               if (op <= 1) begin
                  brg_write(baddr(32 + w), d, bl);
                  brg_m[w] = d;
                  check("rnd_brg_wr_done", 32'(bl > 0), 32'h1);
               end else if (op == 2) begin
                  // Flip one bit of the window tag: must be ignored.
                  brg_write({16'h8000 ^ (16'h1 << $urandom_range(0, 15)), 16'((32 + w) * 4)}, d, bl);
               end else begin
                  brg_read(32 + w, bq, bl);
                  check("rnd_brg_rd", bq, brg_m[w]);
                  check("rnd_brg_lat_ok", 32'(bl >= 3 && bl <= 5), 32'h1);
               end
               repeat ($urandom_range(0, 2)) @(posedge clk);
            end
         end
      join
      check("rnd_no_overflow", 32'(bridge_overflow), 32'h0);

      // ---- contention: CPU held continuously, bridge strobe every 4 cycles ----
      cpu_access(1'b1, 100, 4'hF, 32'hC0DE0100, q, lat);
      for (int k = 0; k < 5; k++) brg_write(baddr(101 + k), 32'hB0000000 + 32'(k), lat);
      both = 0;
      fork
         begin
            @(posedge clk); #1;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd100;
            repeat (40) @(posedge clk);
            #1 cpu_req = 1'b0;
         end
         begin
            for (int k = 0; k < 5; k++) begin
               @(posedge clk); #1;
               bridge_addr = baddr(101 + k); bridge_rd = 1'b1;
               st_q.push_back(cyc);
               ex_q.push_back(32'hB0000000 + 32'(k));
               @(posedge clk); #1;
               bridge_rd = 1'b0;
               repeat (2) @(posedge clk);
            end
         end
         begin
            repeat (46) begin
               @(negedge clk);
               if (cpu_ack && bridge_rd_valid) both++;
               if (cpu_ack) begin
                  ev.push_back(0);
                  check("cont_cpu_q", cpu_q, 32'hC0DE0100);
               end
               if (bridge_rd_valid) begin
                  ev.push_back(1);
                  if (st_q.size() > 0) begin
                     check("cont_brg_lat_le5", 32'((cyc - st_q.pop_front() + 1) <= 5), 32'h1);
                     check("cont_brg_data", bridge_rd_data, ex_q.pop_front());
                  end
               end
            end
         end
      join
      check("cont_no_double_ack", 32'(both), 32'h0);
      first_b = -1; last_b = -1; n_b = 0;
      foreach (ev[i]) begin
         if (ev[i] == 1) begin
            if (first_b < 0) first_b = i;
            last_b = i;
            n_b++;
         end
      end
      check("cont_brg_count", 32'(n_b), 32'd5);
      for (int i = first_b + 1; i <= last_b; i++) begin
         check($sformatf("cont_alternate_%0d", i), 32'(ev[i] != ev[i-1]), 32'h1);
      end
      check("cont_no_overflow", 32'(bridge_overflow), 32'h0);

      // ---- overflow: two back-to-back bridge writes while the CPU is busy ----
      cpu_access(1'b1, 111, 4'hF, 32'h11111111, q, lat);
      cpu_access(1'b1, 110, 4'hF, 32'h00000000, q, lat);
      fork
         begin
            @(posedge clk); #1;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd100;
            repeat (10) @(posedge clk);
            #1 cpu_req = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            bridge_addr = baddr(110); bridge_wr = 1'b1; bridge_wr_data = 32'hA1100001;
            @(negedge clk);
            check("ovf_clear_before", 32'(bridge_overflow), 32'h0);
            @(posedge clk); #1;
            bridge_addr = baddr(111); bridge_wr_data = 32'hA1100002;
            @(posedge clk); #1;
            bridge_wr = 1'b0;
            @(negedge clk);
            check("ovf_set", 32'(bridge_overflow), 32'h1);
         end
      join
      repeat (4) @(posedge clk);
      cpu_access(1'b0, 110, 4'hF, 32'h0, q, lat);
      check("ovf_first_written", q, 32'hA1100001);
      cpu_access(1'b0, 111, 4'hF, 32'h0, q, lat);
      check("ovf_second_dropped", q, 32'h11111111);
      check("ovf_sticky", 32'(bridge_overflow), 32'h1);

      // ---- reset asserted during BRG_ACK: no read-valid pulse follows ----
      @(posedge clk); #1;
      bridge_addr = baddr(110); bridge_rd = 1'b1;
      @(posedge clk); #1;
      bridge_rd = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(bridge_rd_valid), 32'h0);
      check("midrst_rd_data", bridge_rd_data, 32'h0);
      check("midrst_overflow", 32'(bridge_overflow), 32'h0);
      check("midrst_cpu_q", cpu_q, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bridge_rd_valid || bridge_busy) seen = 1;
      end
      check("midrst_no_pulse", 32'(seen), 32'h0);
      cpu_access(1'b0, 110, 4'hF, 32'h0, q, lat);
      check("ram_survives_reset", q, 32'hA1100001);

`ifdef CONTROLLER_RAM_WRITE_PROTECT_EN
      // ---- write protection of the low PROTECT_WORDS words ----
      cpu_access(1'b1, 10, 4'hF, 32'h0A0A0A0A, q, lat);
      cpu_access(1'b1, 300, 4'hF, 32'h03000300, q, lat);
      wp_en = 1'b1;
      cpu_access(1'b1, 10, 4'hF, 32'hFFFFFFFF, q, lat);
      check("wp_write_acked", 32'(lat), 32'd1);
      cpu_access(1'b0, 10, 4'hF, 32'h0, q, lat);
      check("wp_word10_kept", q, 32'h0A0A0A0A);
      cpu_access(1'b1, 300, 4'hF, 32'h0BEEF300, q, lat);
      cpu_access(1'b0, 300, 4'hF, 32'h0, q, lat);
      check("wp_word300_written", q, 32'h0BEEF300);
      brg_write(baddr(10), 32'hB0B0B0B0, lat);
      cpu_access(1'b0, 10, 4'hF, 32'h0, q, lat);
      check("wp_bridge_unprotected", q, 32'hB0B0B0B0);
      wp_en = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
